// File: rtl/key_evt_pkg.sv
// Shared types, defaults and helpers for the key event arbiter.
// Optional debounce is enabled by defining KEY_EVT_DEBOUNCE_EN.
package key_evt_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } arb_state_t;

  localparam int unsigned SYNC_STAGES     = 2;
  localparam int unsigned DEBOUNCE_CYCLES = 4;

  // Round-robin successor with an explicit wrap for non-power-of-2 counts.
  function automatic int unsigned next_rr(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/key_event_arbiter_if.sv
// Key inputs, single-event valid/ready port and status for key_event_arbiter.
interface key_event_arbiter_if #(
  parameter int unsigned N_KEYS = 4
);
  localparam int unsigned ID_W = $clog2(N_KEYS);

  logic [N_KEYS-1:0] key;
  logic              evt_valid;
  logic              evt_ready;
  logic [ID_W-1:0]   evt_id;
  logic [N_KEYS-1:0] pending;
  logic              overflow;

  modport master (
    input  key, evt_ready,
    output evt_valid, evt_id, pending, overflow
  );

  modport slave (
    output key, evt_ready,
    input  evt_valid, evt_id, pending, overflow
  );
endinterface

// File: rtl/key_edge_sync.sv
// Per-key synchroniser, optional debounce filter (KEY_EVT_DEBOUNCE_EN) and rising-edge detect.
module key_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
`ifdef KEY_EVT_DEBOUNCE_EN
  , parameter int unsigned DEBOUNCE_CYCLES = 4
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   level;
  logic                   prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], key_raw};
  end

`ifdef KEY_EVT_DEBOUNCE_EN
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;
  logic             filt_q;

  // Filtered level follows only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else if (sync_q[SYNC_STAGES-1] != filt_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        filt_q <= sync_q[SYNC_STAGES-1];
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_q <= '0;
    end
  end

  assign level = filt_q;
`else
  assign level = sync_q[SYNC_STAGES-1];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev_q <= 1'b0;
    else     prev_q <= level;
  end

  assign rise = level & ~prev_q;

endmodule

// File: rtl/key_event_arbiter.sv
// Turns N push-buttons into single press events shared round-robin on one valid/ready port.
// Define KEY_EVT_DEBOUNCE_EN to insert a debounce filter in every key path.
module key_event_arbiter #(
  parameter int unsigned N_KEYS      = 4,
  parameter int unsigned SYNC_STAGES = key_evt_pkg::SYNC_STAGES
`ifdef KEY_EVT_DEBOUNCE_EN
  , parameter int unsigned DEBOUNCE_CYCLES = key_evt_pkg::DEBOUNCE_CYCLES
`endif
) (
  input logic               clk,
  input logic               rst,
  key_event_arbiter_if.master bus
);
  import key_evt_pkg::*;

  localparam int unsigned ID_W = $clog2(N_KEYS);

  logic [N_KEYS-1:0] rise;
  arb_state_t        state, state_nxt;
  logic [ID_W-1:0]   rr_ptr, rr_nxt, id_nxt, grant_idx;
  logic              grant_found;
  logic [N_KEYS-1:0] ack, pending_nxt;
  logic              ovf_nxt;
  int unsigned       idx;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    key_edge_sync #(
      .SYNC_STAGES     (SYNC_STAGES)
`ifdef KEY_EVT_DEBOUNCE_EN
      , .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`endif
    ) u_sync (
      .clk     (clk),
      .rst     (rst),
      .key_raw (bus.key[i]),
      .rise    (rise[i])
    );
  end

  // Next-state, round-robin search, pending update and overflow detection.
  always_comb begin
    state_nxt   = state;
    rr_nxt      = rr_ptr;
    id_nxt      = bus.evt_id;
    ack         = '0;
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;

    for (int unsigned k = 0; k < N_KEYS; k++) begin
      idx = 32'(rr_ptr) + k;
      if (idx >= N_KEYS) idx = idx - N_KEYS;
      if (!grant_found && bus.pending[ID_W'(idx)]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(idx);
      end
    end

    case (state)
      IDLE: begin
        if (grant_found) begin
          id_nxt    = grant_idx;
          state_nxt = OFFER;
        end
      end
      OFFER: begin
        if (bus.evt_ready) begin
          ack[bus.evt_id] = 1'b1;
          rr_nxt          = ID_W'(next_rr(32'(bus.evt_id), N_KEYS));
          state_nxt       = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // A press arriving with its own ack is kept; one arriving on a still-pending key is dropped.
    pending_nxt = rise | (bus.pending & ~ack);
    ovf_nxt     = |(rise & bus.pending & ~ack);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      bus.evt_id    <= '0;
      bus.evt_valid <= 1'b0;
      bus.pending   <= '0;
      bus.overflow  <= 1'b0;
    end else begin
      state         <= state_nxt;
      rr_ptr        <= rr_nxt;
      bus.evt_id    <= id_nxt;
      bus.evt_valid <= (state_nxt == OFFER);
      bus.pending   <= pending_nxt;
      bus.overflow  <= ovf_nxt;
    end
  end

endmodule
